// File: rtl/panda_top_bench.sv
// Position-capture sampler: timestamps masked TTL rising edges while armed and
// buffers {timestamp, pads} in a FIFO readable through a 32-bit register port.
module panda_top_bench #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              pcap_armed,
  input  logic [5:0]        ttlin_pad,
  input  logic              reg_wr_i,
  input  logic              reg_rd_i,
  input  logic [ADDR_W-1:0] reg_addr_i,
  input  logic [31:0]       reg_wdata_i,
  output logic [31:0]       reg_rdata_o,
  output logic              reg_rack_o,
  output logic              irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic          armed_d;
  logic [5:0]    ttlin_d;
  logic [5:0]    trig_mask;
  logic [5:0]    framing_mask;
  logic [15:0]   irq_thresh;
  logic [15:0]   smpl_count;
  logic [25:0]   ts;
  logic          push_req;
  logic [31:0]   push_data;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [7:0]    irq_flags;
  logic [15:0]   flag_count;

  logic          arm_rise;
  logic          arm_fall;
  logic          trig_hit;
  logic          fifo_empty;
  logic          fifo_full;
  logic          clear;
  logic          pop;
  logic          push_ok;
  logic          overflow;
  logic          count_inc;
  logic          thresh_hit;
  logic          irq_read;
  logic [15:0]   count_plus;
  logic [15:0]   count_next;
  logic [7:0]    flag_set;
  logic [7:0]    flags_next;
  logic [15:0]   flag_count_next;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  assign unused_bits = ^reg_wdata_i[31:16];

  assign arm_rise   = pcap_armed & ~armed_d;
  assign arm_fall   = ~pcap_armed & armed_d;
  assign trig_hit   = armed_d & (|(ttlin_pad & ~ttlin_d & trig_mask));
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign clear      = reg_wr_i && (reg_addr_i == ADDR_W'(7)) && reg_wdata_i[0];
  assign pop        = reg_rd_i && (reg_addr_i == ADDR_W'(6)) && !fifo_empty && !clear;
  assign push_ok    = push_req && !fifo_full && !clear;
  assign overflow   = push_req && fifo_full && !clear;
  assign irq_read   = reg_rd_i && (reg_addr_i == ADDR_W'(4));
  assign count_plus = smpl_count + 16'd1;
  assign count_inc  = push_ok && (smpl_count != 16'hFFFF) && !arm_rise;
  assign thresh_hit = count_inc && (irq_thresh != '0) && (count_plus == irq_thresh);
  assign flag_set   = {5'b0, overflow, thresh_hit, arm_fall};

  always_comb begin
    count_next = smpl_count;
    if (arm_rise || clear) count_next = '0;
    else if (count_inc)    count_next = count_plus;
  end

  // A flag raised in the read cycle is OR-ed in after the clear so it survives.
  always_comb begin
    flags_next      = (irq_read ? '0 : irq_flags) | flag_set;
    flag_count_next = flag_count;
    if (flag_set != '0) flag_count_next = count_next;
    else if (irq_read)  flag_count_next = '0;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr_i)
      ADDR_W'(0): rd_mux = {26'b0, trig_mask};
      ADDR_W'(1): rd_mux = {26'b0, framing_mask};
      ADDR_W'(2): rd_mux = {16'b0, irq_thresh};
      ADDR_W'(3): rd_mux = {8'b0, 16'(level), 5'b0, fifo_full, fifo_empty, armed_d};
      ADDR_W'(4): rd_mux = {flag_count, 8'b0, irq_flags};
      ADDR_W'(5): rd_mux = {16'b0, smpl_count};
      ADDR_W'(6): rd_mux = fifo_empty ? '0 : mem[rd_ptr];
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      armed_d      <= 1'b0;
      ttlin_d      <= '0;
      trig_mask    <= '0;
      framing_mask <= '0;
      irq_thresh   <= '0;
      smpl_count   <= '0;
      ts           <= '0;
      push_req     <= 1'b0;
      push_data    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      irq_flags    <= '0;
      flag_count   <= '0;
      irq_o        <= 1'b0;
      reg_rack_o   <= 1'b0;
      reg_rdata_o  <= '0;
    end else begin
      armed_d <= pcap_armed;
      ttlin_d <= ttlin_pad;
      if (arm_rise)     ts <= '0;
      else if (armed_d) ts <= ts + 26'd1;
      push_req  <= trig_hit;
      push_data <= {ts, ttlin_pad & ~framing_mask};
      if (reg_wr_i) begin
        case (reg_addr_i)
          ADDR_W'(0): trig_mask    <= reg_wdata_i[5:0];
          ADDR_W'(1): framing_mask <= reg_wdata_i[5:0];
          ADDR_W'(2): irq_thresh   <= reg_wdata_i[15:0];
          default: ;
        endcase
      end
      smpl_count <= count_next;
      irq_flags  <= flags_next;
      flag_count <= flag_count_next;
      irq_o      <= |flags_next;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (pop)     rd_ptr <= rd_ptr + PW'(1);
        level <= level + LW'(push_ok) - LW'(pop);
      end
      reg_rack_o  <= reg_rd_i;
      reg_rdata_o <= reg_rd_i ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_panda_top_bench.sv
// Scoreboarded bench: stimulus queues expected read data from a sample-level
// model; a monitor compares each acknowledged read.
module tb_panda_top_bench;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              pcap_armed;
  logic [5:0]        ttlin_pad;
  logic              reg_wr_i;
  logic              reg_rd_i;
  logic [ADDR_W-1:0] reg_addr_i;
  logic [31:0]       reg_wdata_i;
  logic [31:0]       reg_rdata_o;
  logic              reg_rack_o;
  logic              irq_o;

  panda_top_bench #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .pcap_armed  (pcap_armed),
    .ttlin_pad   (ttlin_pad),
    .reg_wr_i    (reg_wr_i),
    .reg_rd_i    (reg_rd_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o),
    .reg_rack_o  (reg_rack_o),
    .irq_o       (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  int          addr_q[$];
  bit          tol_q[$];

  // Reference model: samples, count, flags and configuration as plain values.
  logic [31:0] mfifo[$];
  int          mcount;
  logic [7:0]  mflags;
  int          mflag_cnt;
  logic [5:0]  mtrig, mframe, mprev;
  int          mthresh;
  bit          marmed;
  int          off;

  function automatic string rname(int a);
    case (a)
      0: return "TRIG_MASK";
      1: return "FRAMING_MASK";
      2: return "IRQ_THRESH";
      3: return "STATUS";
      4: return "IRQ_STATUS";
      5: return "SMPL_COUNT";
      6: return "FIFO_DATA";
      default: return "UNMAPPED";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (reg_rack_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rack: got data 0x%08h expected no acknowledge", reg_rdata_o);
      end else begin
        logic [31:0] e;
        int a;
        bit t;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        t = tol_q.pop_front();
        if (t) begin
          logic [25:0] ats, ets;
          ats = reg_rdata_o[31:6];
          ets = e[31:6];
          n_checks++;
          if (reg_rdata_o[5:0] !== e[5:0] ||
              !(ats == ets || ats == ets + 26'd1 || ats + 26'd1 == ets)) begin
            n_fail++;
            $display("FAIL FIFO_DATA: got 0x%08h expected 0x%08h (timestamp +-1)", reg_rdata_o, e);
          end
        end else begin
          check(rname(a), reg_rdata_o, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    off++;
  endtask

  task automatic model_reset();
    mfifo.delete();
    mcount = 0; mflags = '0; mflag_cnt = 0;
    mtrig = '0; mframe = '0; mprev = '0; mthresh = 0; marmed = 0;
  endtask

  task automatic model_push(input logic [31:0] s);
    if (mfifo.size() < DEPTH) begin
      mfifo.push_back(s);
      if (mcount < 65535) begin
        mcount++;
        if (mthresh != 0 && mcount == mthresh) begin
          mflags[1] = 1'b1;
          mflag_cnt = mcount;
        end
      end
    end else begin
      mflags[2] = 1'b1;
      mflag_cnt = mcount;
    end
  endtask

  task automatic reg_read(input int a);
    logic [31:0] e;
    int lvl;
    bit t;
    t = 0;
    lvl = mfifo.size();
    case (a)
      0: e = {26'b0, mtrig};
      1: e = {26'b0, mframe};
      2: e = 32'(mthresh);
      3: e = {8'b0, 16'(lvl), 5'b0, (lvl == DEPTH), (lvl == 0), marmed};
      4: begin
        e = {16'(mflag_cnt), 8'b0, mflags};
        mflags = '0;
        mflag_cnt = 0;
      end
      5: e = 32'(mcount);
      6: begin
        if (lvl == 0) e = '0;
        else begin
          e = mfifo.pop_front();
          t = 1;
        end
      end
      default: e = '0;
    endcase
    exp_q.push_back(e);
    addr_q.push_back(a);
    tol_q.push_back(t);
    reg_addr_i = ADDR_W'(a);
    reg_rd_i = 1'b1;
    tick();
    reg_rd_i = 1'b0;
    tick();
  endtask

  task automatic reg_write(input int a, input logic [31:0] d);
    case (a)
      0: mtrig = d[5:0];
      1: mframe = d[5:0];
      2: mthresh = int'(d[15:0]);
      7: if (d[0]) begin
        mfifo.delete();
        mcount = 0;
      end
      default: ;
    endcase
    reg_addr_i = ADDR_W'(a);
    reg_wdata_i = d;
    reg_wr_i = 1'b1;
    tick();
    reg_wr_i = 1'b0;
    tick();
  endtask

  task automatic check_irq();
    check("irq_o", 32'(irq_o), 32'(mflags != '0));
  endtask

  task automatic arm();
    pcap_armed = 1'b1;
    tick();
    marmed = 1;
    off = 0;
    mcount = 0;
  endtask

  task automatic drive(input logic [5:0] v);
    if (marmed && ((v & ~mprev & mtrig) != '0))
      model_push({off[25:0], v & ~mframe});
    mprev = v;
    ttlin_pad = v;
    tick();
  endtask

  task automatic disarm();
    repeat (3) drive(6'd0);
    pcap_armed = 1'b0;
    tick();
    marmed = 0;
    mflags[0] = 1'b1;
    mflag_cnt = mcount;
    tick();
  endtask

  task automatic drain();
    int n;
    n = mfifo.size();
    repeat (n) reg_read(6);
    reg_read(6);
  endtask

  task automatic pulse_run(input int o1, input int o2, input int o3, input int len);
    for (int i = 0; i < len; i++)
      drive((off == o1 || off == o2 || off == o3) ? 6'd1 : 6'd0);
  endtask

  task automatic summary_reads();
    reg_read(5);
    reg_read(3);
    reg_read(4);
    check_irq();
  endtask

  initial begin
    model_reset();
    off = 0;
    reset_n_i = 1'b0;
    pcap_armed = 1'b0;
    ttlin_pad = '0;
    reg_wr_i = 1'b0;
    reg_rd_i = 1'b0;
    reg_addr_i = '0;
    reg_wdata_i = '0;
    repeat (3) tick();
    check("reset_irq_o", 32'(irq_o), 32'd0);
    check("reset_rack", 32'(reg_rack_o), 32'd0);
    check("reset_rdata", reg_rdata_o, 32'd0);
    reset_n_i = 1'b1;
    tick();

    check_irq();
    reg_read(3);
    reg_read(5);
    reg_read(6);
    reg_read(4);
    reg_read(9);

    // Three edges at offsets 10/20/30
    reg_write(0, 32'h01);
    arm();
    pulse_run(10, 20, 30, 40);
    disarm();
    summary_reads();
    drain();

    // Framing mask hides bit 0
    reg_write(1, 32'h01);
    reg_read(1);
    arm();
    pulse_run(10, 20, 30, 40);
    disarm();
    summary_reads();
    drain();
    reg_write(1, 32'h00);

    // Threshold interrupt at two samples
    reg_write(2, 32'd2);
    reg_read(2);
    arm();
    pulse_run(5, -1, -1, 9);
    check_irq();
    pulse_run(12, -1, -1, 8);
    check_irq();
    reg_read(4);
    check_irq();
    disarm();
    reg_read(4);
    check_irq();
    drain();
    reg_write(2, 32'd0);

    // Overflow: 20 edges into 16 entries
    arm();
    for (int i = 0; i < 20; i++) begin
      drive(6'd1);
      drive(6'd0);
    end
    disarm();
    summary_reads();
    drain();

    // CLEAR after 5 samples, then timestamp restart on re-arm
    arm();
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(1, 4)) drive(6'd0);
      drive(6'd1);
    end
    disarm();
    reg_write(7, 32'h1);
    reg_read(3);
    reg_read(5);
    reg_read(4);
    arm();
    pulse_run(7, -1, -1, 12);
    disarm();
    reg_read(4);
    drain();

    // Randomised captures
    for (int it = 0; it < 6; it++) begin
      reg_write(0, 32'($urandom_range(1, 63)));
      reg_write(1, 32'($urandom_range(0, 63)));
      reg_write(2, 32'($urandom_range(0, 10)));
      reg_read(0);
      arm();
      for (int s = 0; s < 40; s++) drive(6'($urandom_range(0, 63)));
      disarm();
      summary_reads();
      drain();
    end

    // Reset mid-capture
    reg_write(0, 32'h3f);
    arm();
    for (int s = 0; s < 6; s++) drive(6'($urandom_range(0, 63)));
    drive(6'd0);
    drive(6'd0);
    reset_n_i = 1'b0;
    pcap_armed = 1'b0;
    ttlin_pad = '0;
    tick();
    model_reset();
    check("midreset_irq_o", 32'(irq_o), 32'd0);
    tick();
    reset_n_i = 1'b1;
    tick();
    reg_read(3);
    reg_read(5);
    reg_read(4);
    reg_read(0);
    reg_read(6);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending reads expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/panda_top_bench.md
Name: panda_top_bench

Overview:
- Stand-alone position-capture (PCAP) sampler wrapped around the TTL input pads. Bench-facing top for the carrier design.
- While an external arm input is high, it timestamps trigger edges on the 6 TTL inputs and pushes the samples into a FIFO.
- Raises an interrupt when a threshold is reached, when the FIFO overflows and when capture completes.
- All configuration and readout goes through a simple 32-bit register port.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries (power of two, 4..256).
- ADDR_W, 4, register word-address width.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- pcap_armed  in  1  capture enable/arm level.
- ttlin_pad  in  6  TTL inputs, synchronous to clk_i.
- reg_wr_i  in  1  register write strobe (1 cycle).
- reg_rd_i  in  1  register read strobe (1 cycle).
- reg_addr_i  in  ADDR_W  register word address.
- reg_wdata_i  in  32  write data.
- reg_rdata_o  out  32  read data, valid 1 cycle after reg_rd_i.
- reg_rack_o  out  1  read acknowledge, pulses with reg_rdata_o.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset: every output is 0. All registers, the FIFO pointers, the timestamp and the count are cleared.
- Registers (word address):
  - 0 TRIG_MASK[5:0], RW.
  - 1 FRAMING_MASK[5:0], RW.
  - 2 IRQ_THRESH[15:0], RW, 0 = disabled.
  - 3 STATUS, RO: bit0 armed_d, bit1 fifo_empty, bit2 fifo_full, [23:8] fifo level.
  - 4 IRQ_STATUS, RO, clear-on-read: [7:0] IRQ_FLAGS, [31:16] SMPL_COUNT at the time of the flag.
  - 5 SMPL_COUNT[15:0], RO.
  - 6 FIFO_DATA, RO, read pops one entry; reading while empty returns 0 and does not pop.
  - 7 CLEAR, WO: bit0 flushes the FIFO and zeroes SMPL_COUNT.
  - Unmapped addresses read 0; writes to them are ignored.
- Arm handling:
  - armed_d = pcap_armed registered once.
  - Rising edge of armed_d: timestamp := 0 and SMPL_COUNT := 0. The FIFO is not flushed.
  - Falling edge of armed_d: set IRQ_FLAGS bit0 (completed).
- Timestamp: 26-bit counter that increments every cycle while armed_d = 1 and wraps from 2^26-1 to 0.
- Trigger:
  - edge = ttlin_pad & ~ttlin_d & TRIG_MASK, where ttlin_d is ttlin_pad delayed one cycle.
  - If armed_d and |edge, push {timestamp[25:0], ttlin_pad & ~FRAMING_MASK} one cycle later and increment SMPL_COUNT (saturates at 0xFFFF).
  - Only one push per cycle, however many bits edged.
- Overflow: a push while the FIFO is full discards the sample, sets IRQ_FLAGS bit2 and does not increment SMPL_COUNT.
- Threshold: when SMPL_COUNT becomes equal to a nonzero IRQ_THRESH, set IRQ_FLAGS bit1 (once per crossing).
- Simultaneous push and pop are both honoured; the level is unchanged.
- irq_o = |IRQ_FLAGS, registered.
- Clear-on-read zeroes IRQ_FLAGS in the cycle after the read. A flag raised in that same cycle survives.
- CLEAR during capture flushes the FIFO. A push in the same cycle is dropped.
- Reset asserted mid-capture returns everything to the reset state immediately.

Test Plan:
- Reset then idle -> irq_o = 0; STATUS = 0x2 (empty); SMPL_COUNT = 0; FIFO_DATA reads 0.
- TRIG_MASK = 0x01, arm, pulse ttlin_pad[0] at cycle offsets 10, 20 and 30 after armed_d, then disarm -> SMPL_COUNT = 3, level = 3, IRQ_FLAGS = 0x01. FIFO_DATA timestamps are 10, 20 and 30 (±1 fixed latency), each with low bits 0x01.
- FRAMING_MASK = 0x01, same stimulus -> low 6 bits of every sample read as 0.
- IRQ_THRESH = 2, arm, two edges -> irq_o rises after the second push. An IRQ_STATUS read returns 0x0002_0002, and irq_o drops one cycle after the read.
- FIFO_DEPTH = 16, 20 edges while armed -> SMPL_COUNT = 16, STATUS bit2 = 1, IRQ_FLAGS bit2 = 1. The first 16 samples read back in order.
- 5 samples captured, write CLEAR = 1 -> level 0, SMPL_COUNT 0, flags unchanged. Re-arming restarts the timestamp at 0.
